// File: rtl/tpu_core_nxn.sv
// NxN output-stationary systolic matrix engine: loads W then X element-serially,
// computes X*W (or X*W^T), then streams post-processed results row-major.
module tpu_core_nxn #(
   parameter int N      = 2,
   parameter int DATA_W = 8,
   parameter int ACC_W  = 2*DATA_W + $clog2(N) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              mode_transpose,
   input  logic              mode_relu,
   input  logic              mode_sat,
   input  logic              abort,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              busy,
   output logic              done
);

   localparam int NN    = N*N;
   localparam int IDX_W = $clog2(NN);
   localparam int CNT_W = $clog2(2*NN);
   localparam int T_W   = $clog2(3*N-2);

   localparam logic [CNT_W-1:0] LD_LAST = CNT_W'(2*NN-1);
   localparam logic [CNT_W-1:0] W_END   = CNT_W'(NN);
   localparam logic [T_W-1:0]   T_LAST  = T_W'(3*N-3);
   localparam logic [IDX_W-1:0] O_LAST  = IDX_W'(NN-1);
   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2**(DATA_W-1) - 1);
   localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

   typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_DRAIN} state_t;

   state_t state, state_nxt;

   logic [CNT_W-1:0] ld_cnt;
   logic [T_W-1:0]   t_cnt;
   logic [IDX_W-1:0] o_idx;
   logic             md_tr, md_relu, md_sat;
   logic             flush, ld_fire, ld_last, out_fire, pe_clr, pe_en;

   logic signed [DATA_W-1:0] w_mem [NN];
   logic signed [DATA_W-1:0] x_mem [NN];
   logic signed [DATA_W-1:0] a_feed [N];
   logic signed [DATA_W-1:0] b_feed [N];
   logic signed [DATA_W-1:0] a_p [NN];
   logic signed [DATA_W-1:0] b_p [NN];
   logic signed [ACC_W-1:0]  acc [NN];

   function automatic logic signed [DATA_W-1:0] post_proc(
      input logic signed [ACC_W-1:0] v,
      input logic                    relu,
      input logic                    sat
   );
      logic signed [ACC_W-1:0] r;
      r = (relu && v < 0) ? '0 : v;
      if (sat && r > SAT_HI) return SAT_HI[DATA_W-1:0];
      if (sat && r < SAT_LO) return SAT_LO[DATA_W-1:0];
      return r[DATA_W-1:0];
   endfunction

   assign flush    = rst | abort;
   assign ld_fire  = (state == S_LOAD) && in_valid;
   assign ld_last  = ld_fire && (ld_cnt == LD_LAST);
   assign out_fire = (state == S_DRAIN) && out_ready;
   assign pe_clr   = flush | ld_last;
   assign pe_en    = (state == S_COMPUTE);

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         S_LOAD: begin
            in_ready = 1'b1;
            if (ld_last) state_nxt = S_COMPUTE;
         end
         S_COMPUTE: begin
            busy = 1'b1;
            if (t_cnt == T_LAST) state_nxt = S_DRAIN;
         end
         S_DRAIN: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            if (out_ready && o_idx == O_LAST) begin
               done      = ~flush;
               state_nxt = S_LOAD;
            end
         end
         default: state_nxt = S_LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (flush) state <= S_LOAD;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         ld_cnt  <= '0;
         t_cnt   <= '0;
         o_idx   <= '0;
         md_tr   <= 1'b0;
         md_relu <= 1'b0;
         md_sat  <= 1'b0;
      end else begin
         if (ld_fire) ld_cnt <= ld_last ? '0 : ld_cnt + 1'b1;
         if (pe_en)   t_cnt  <= (t_cnt == T_LAST) ? '0 : t_cnt + 1'b1;
         if (out_fire) o_idx <= (o_idx == O_LAST) ? '0 : o_idx + 1'b1;
         if (ld_last) begin
            md_tr   <= mode_transpose;
            md_relu <= mode_relu;
            md_sat  <= mode_sat;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (ld_fire && !flush) begin
         if (ld_cnt < W_END) w_mem[ld_cnt[IDX_W-1:0]] <= in_data;
         else                x_mem[IDX_W'(ld_cnt - W_END)] <= in_data;
      end
   end

   // Skewed edge feed: row i sees X[i][t-i], column j sees B[t-j][j]
   always_comb begin
      for (int i = 0; i < N; i++) begin
         a_feed[i] = '0;
         b_feed[i] = '0;
         for (int k = 0; k < N; k++) begin
            if (t_cnt == T_W'(i + k)) begin
               a_feed[i] = x_mem[i*N + k];
               b_feed[i] = md_tr ? w_mem[i*N + k] : w_mem[k*N + i];
            end
         end
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_row
      for (genvar gj = 0; gj < N; gj++) begin : g_col
         localparam int P = gi*N + gj;
         logic signed [DATA_W-1:0]   a_in, b_in;
         logic signed [2*DATA_W-1:0] prod;

         if (gj == 0) begin : g_a_edge
            assign a_in = a_feed[gi];
         end else begin : g_a_pass
            assign a_in = a_p[P-1];
         end
         if (gi == 0) begin : g_b_edge
            assign b_in = b_feed[gj];
         end else begin : g_b_pass
            assign b_in = b_p[P-N];
         end

         assign prod = a_in * b_in;

         // PE stage: operands advance one PE per cycle, product accumulates in place
         always_ff @(posedge clk) begin
            if (pe_clr) begin
               a_p[P] <= '0;
               b_p[P] <= '0;
               acc[P] <= '0;
            end else if (pe_en) begin
               a_p[P] <= a_in;
               b_p[P] <= b_in;
               acc[P] <= acc[P] + ACC_W'(prod);
            end
         end
      end
   end

   assign out_data = (state == S_DRAIN) ? post_proc(acc[o_idx], md_relu, md_sat) : '0;

endmodule

// File: tb/tb_tpu_core_nxn.sv
// Directed bench for tpu_core_nxn: N=2 scenarios with hand-computed results,
// plus an N=4 instance checked against a plain matrix-product model.
module tb_tpu_core_nxn;

   logic       clk = 1'b0;
   logic       rst, abort;
   logic       mode_transpose, mode_relu, mode_sat;
   logic       in_valid, out_ready;
   logic [7:0] in_data;
   logic       in_ready, out_valid, busy, done;
   logic [7:0] out_data;

   logic       in_valid4, out_ready4;
   logic [7:0] in_data4;
   logic       in_ready4, out_valid4, busy4, done4;
   logic [7:0] out_data4;

   int n_chk = 0;
   int n_fail = 0;
   int n_done = 0;

   logic [7:0] ld [8];
   logic [7:0] ex [4];

   always #5 clk = ~clk;

   always @(posedge clk) if (done) n_done++;

   tpu_core_nxn #(.N(2), .DATA_W(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .mode_transpose(mode_transpose), .mode_relu(mode_relu), .mode_sat(mode_sat),
      .abort(abort), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .done(done)
   );

   tpu_core_nxn #(.N(4), .DATA_W(8)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
      .mode_transpose(mode_transpose), .mode_relu(mode_relu), .mode_sat(mode_sat),
      .abort(abort), .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
      .busy(busy4), .done(done4)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_in_ready"}, in_ready, 1);
      check({tag, "_out_valid"}, out_valid, 0);
      check({tag, "_out_data"}, out_data, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
   endtask

   task automatic load2(input bit gaps);
      for (int k = 0; k < 8; k++) begin
         if (gaps && (k % 3 == 1)) begin
            in_valid = 1'b0;
            in_data  = 8'hAA;
            @(negedge clk);
         end
         in_valid = 1'b1;
         in_data  = ld[k];
         check("in_ready_load", in_ready, 1);
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_out2(input bit noise);
      int lat;
      lat = 0;
      check("busy_compute", busy, 1);
      check("in_ready_compute", in_ready, 0);
      while (!out_valid && lat < 40) begin
         if (noise) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
         end
         @(negedge clk);
         lat++;
      end
      check("latency", lat, 4);
   endtask

   task automatic drain2(input bit stall);
      int idx, guard;
      idx = 0;
      guard = 0;
      while (idx < 4 && guard < 200) begin
         out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (stall) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
         end
         #1;
         check("out_valid", out_valid, 1);
         check("out_data", out_data, ex[idx]);
         if (stall) check("in_ready_drain", in_ready, 0);
         if (out_ready) begin
            check("done", done, (idx == 3));
            idx++;
         end else begin
            check("done_stall", done, 0);
         end
         @(negedge clk);
         guard++;
      end
      if (idx < 4) check("drain_timeout", idx, 4);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      check_idle("after_drain");
   endtask

   task automatic run2(input bit tr, input bit relu, input bit sat, input bit gaps);
      int d0;
      mode_transpose = tr;
      mode_relu      = relu;
      mode_sat       = sat;
      d0 = n_done;
      load2(gaps);
      wait_out2(gaps);
      drain2(gaps);
      check("done_count", n_done - d0, 1);
   endtask

   task automatic run4();
      int wm [16];
      int xm [16];
      int c, lat, idx;
      logic [7:0] e4 [16];
      for (int k = 0; k < 16; k++) begin
         wm[k] = k - 7;
         xm[k] = (k % 5) * 3 - 6;
      end
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            c = 0;
            for (int k = 0; k < 4; k++) c += xm[i*4 + k] * wm[k*4 + j];
            e4[i*4 + j] = 8'(c);
         end
      mode_transpose = 1'b0;
      mode_relu      = 1'b0;
      mode_sat       = 1'b0;
      for (int k = 0; k < 32; k++) begin
         in_valid4 = 1'b1;
         in_data4  = (k < 16) ? 8'(wm[k]) : 8'(xm[k-16]);
         @(negedge clk);
      end
      in_valid4 = 1'b0;
      lat = 0;
      while (!out_valid4 && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      check("n4_latency", lat, 10);
      out_ready4 = 1'b1;
      idx = 0;
      while (idx < 16 && out_valid4) begin
         #1;
         check("n4_out_data", out_data4, e4[idx]);
         if (idx == 15) check("n4_done", done4, 1);
         idx++;
         @(negedge clk);
      end
      check("n4_count", idx, 16);
      out_ready4 = 1'b0;
      check("n4_idle", out_valid4, 0);
   endtask

   initial begin
      rst = 1'b1;
      abort = 1'b0;
      mode_transpose = 1'b0;
      mode_relu = 1'b0;
      mode_sat = 1'b0;
      in_valid = 1'b0;
      in_data = 8'h00;
      out_ready = 1'b0;
      in_valid4 = 1'b0;
      in_data4 = 8'h00;
      out_ready4 = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      check_idle("reset");

      ld = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
      ex = '{8'd23, 8'd34, 8'd31, 8'd46};
      run2(0, 0, 0, 0);

      ex = '{8'd17, 8'd39, 8'd23, 8'd53};
      run2(1, 0, 0, 0);

      ld = '{8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127, 8'd127};
      ex = '{8'd127, 8'd127, 8'd127, 8'd127};
      run2(0, 0, 1, 0);
      ex = '{8'h02, 8'h02, 8'h02, 8'h02};
      run2(0, 0, 0, 0);

      ld = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'd5, 8'd6, 8'd7, 8'd8};
      ex = '{8'hFB, 8'hFA, 8'hF9, 8'hF8};
      run2(0, 0, 0, 0);
      ex = '{8'h00, 8'h00, 8'h00, 8'h00};
      run2(0, 1, 0, 0);

      ld = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
      ex = '{8'd23, 8'd34, 8'd31, 8'd46};
      run2(0, 0, 0, 1);

      // abort after five loaded elements, with a sixth offered in the same cycle
      mode_transpose = 1'b0;
      mode_relu = 1'b0;
      mode_sat = 1'b0;
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1;
         in_data  = ld[k];
         @(negedge clk);
      end
      in_data = ld[5];
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      in_valid = 1'b0;
      #1;
      check_idle("abort_load");
      run2(0, 0, 0, 0);

      // abort after two drained results
      begin
         int d0;
         d0 = n_done;
         load2(0);
         wait_out2(0);
         out_ready = 1'b1;
         repeat (2) @(negedge clk);
         #1;
         check("pre_abort_data", out_data, ex[2]);
         abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
         out_ready = 1'b0;
         #1;
         check_idle("abort_drain");
         check("abort_no_done", n_done - d0, 0);
      end
      run2(0, 0, 0, 0);

      run4();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/tpu_core_nxn.md
Name: tpu_core_nxn

Overview:
Parametrised successor to the 2x2 byte-serial TPU top. The block holds an NxN signed weight matrix W and an NxN input matrix X, both loaded one element per transfer. It computes C = X·W, or X·Wᵀ in transpose mode, on an internal NxN output-stationary systolic array with skewed operand feed. Results are post-processed (optional ReLU, then saturate or truncate) and streamed out through a valid/ready handshake. It replaces the fixed 2x2 memory/control/feeder trio and sits behind the host byte interface.

Parameters:
N, 2, array dimension (matrices are NxN); legal range 2..8.
DATA_W, 8, width of operands and output elements, signed two's complement.
ACC_W, 2*DATA_W+$clog2(N)+1, accumulator width; must never overflow for any operands.

Ports:
clk  input  1  clock, all logic on rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  host presents in_data.
in_ready  output  1  block accepts an element this cycle.
in_data  input  DATA_W  element; W row-major first, then X row-major.
mode_transpose  input  1  use Wᵀ; sampled on the LOAD->COMPUTE transition.
mode_relu  input  1  clamp negative results to 0; sampled on the same transition.
mode_sat  input  1  1 = saturate to DATA_W signed range, 0 = keep low DATA_W bits; sampled on the same transition.
abort  input  1  synchronous flush back to empty LOAD.
out_valid  output  1  out_data holds a result.
out_ready  input  1  host consumes the result.
out_data  output  DATA_W  post-processed C element, row-major.
busy  output  1  high in COMPUTE and DRAIN.
done  output  1  single-cycle pulse when the last result is accepted.

Behaviour:
- Reset/abort values: state=LOAD, load count=0, accumulators=0, in_ready=1, out_valid=0, out_data=0, busy=0, done=0. abort has the same effect as rst, except stored W/X contents are don't-care.
- Transfer rule: an element transfers when valid && ready in the same cycle. Data is held stable while valid && !ready (applies to both in and out sides).
- LOAD:
  - in_ready=1.
  - Accepted elements 0..N²-1 go to W[k/N][k%N]; elements N²..2N²-1 go to X.
  - Acceptance of element 2N²-1 latches the three mode bits, clears all accumulators, and moves to COMPUTE on the next cycle.
- COMPUTE:
  - in_ready=0, busy=1. Lasts exactly 3N-2 cycles.
  - On cycle t (0-based), row i of the array receives X[i][t-i]; column j receives B[t-j][j], where B=W or Wᵀ. Out-of-range indices feed 0.
  - Operands propagate one PE per cycle; each PE does acc += a*b with full-width signed multiply.
  - After the last cycle, go to DRAIN.
- DRAIN:
  - out_valid=1, busy=1. Results are emitted in order C[0][0], C[0][1] … C[N-1][N-1].
  - Post-processing: r = acc; if relu and r<0 then r=0. If sat, clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; else take r[DATA_W-1:0].
  - The index advances only on out_ready. Acceptance of the last element pulses done and returns to LOAD with count=0 the next cycle.
  - W/X storage is not retained for reuse; a full 2N² reload is required.
- Input ignored: in_valid during COMPUTE/DRAIN is ignored with no state change. in_valid=0 during LOAD stalls indefinitely.
- Latency: 3N-2 cycles from the last load acceptance to the first out_valid; N² cycles minimum drain.
- Precedence: simultaneous rst and abort are treated as reset. abort has priority over any transfer in the same cycle.

Test Plan:
- N=2, W=[[1,2],[3,4]], X=[[5,6],[7,8]], modes 0, out_ready=1 -> out sequence 23,34,31,46. First out_valid 4 cycles after the 8th accept; done pulses once.
- Same data, mode_transpose=1 -> 17,39,23,53.
- W all 127, X all 127: mode_sat=1 -> four outputs of 127. mode_sat=0 -> four outputs of 0x02 (32258=0x7E02).
- W=[[-1,0],[0,-1]], X=[[5,6],[7,8]]: relu=0 -> -5,-6,-7,-8 (0xFB,0xFA,0xF9,0xF8); relu=1 -> 0,0,0,0.
- Backpressure: toggle out_ready pseudo-randomly and in_valid with gaps -> identical result sequence, out_data stable while stalled, in_ready=0 through COMPUTE/DRAIN.
- Assert abort mid-LOAD (after 5 elements) and mid-DRAIN (after 2 results) -> outputs return to reset values next cycle. A subsequent full load yields correct results. Repeat the first scenario at N=4 against a reference model.
